// File: rtl/bus_decoder_pkg.sv
// Purpose : shared types for the bus decoder (FSM state and error codes).
// Latency : n/a (types only).
// Backpressure: n/a (types only).
package bus_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_DECODE  = 2'd1,
    ERR_ALIGN   = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_e;

endpackage

// File: rtl/bus_decoder_if.sv
// Purpose : master-side request bus plus per-slave strobes seen by the decoder.
// Latency : n/a (wires only).
// Backpressure: request is held by the master until o_ack or o_err.
// Ports   : slave modport = decoder view (requests/slave strobes in, selects/response out);
//           master modport = the opposite direction, for the requester/environment.
interface bus_decoder_if
  import bus_decoder_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]            i_address;
  logic                             i_req;
  logic [NUM_SLAVES-1:0]            i_slave_ack;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] i_slave_data;
  logic [NUM_SLAVES-1:0]            o_cs;
  logic                             o_ack;
  logic                             o_err;
  err_code_e                        o_err_code;
  logic [DATA_WIDTH-1:0]            o_data;

  modport slave (
    input  i_address, i_req, i_slave_ack, i_slave_data,
    output o_cs, o_ack, o_err, o_err_code, o_data
  );

  modport master (
    output i_address, i_req, i_slave_ack, i_slave_data,
    input  o_cs, o_ack, o_err, o_err_code, o_data
  );

endinterface

// File: rtl/bus_decoder_region_match.sv
// Purpose : combinational single-region comparator, base <= addr < base + span.
// Latency : 0 cycles (pure combinational).
// Backpressure: none.
// Ports   : i_base/i_span/i_address (ADDR_WIDTH) in, o_hit out.
module region_match #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] i_base,
  input  logic [ADDR_WIDTH-1:0] i_span,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic                  o_hit
);

  // One extra bit so a region ending at the top of the address space does
  // not wrap to zero; a zero span gives end == base and never matches.
  logic [ADDR_WIDTH:0] end_excl;

  assign end_excl = {1'b0, i_base} + {1'b0, i_span};
  assign o_hit    = (i_address >= i_base) && ({1'b0, i_address} < end_excl);

endmodule

// File: rtl/bus_decoder.sv
// Purpose : decode request address to one of NUM_SLAVES regions, hold a registered
//           one-hot chip select until that slave acks, report ack/data or error.
// Latency : cs from cycle 1 after request; o_ack one cycle after slave ack; errors in cycle 1.
// Backpressure: master holds i_req until o_ack/o_err; at most one transaction per 3 cycles.
// Ports   : i_clk, i_rst_n (async active-low); bus = bus_decoder_if.slave.
module bus_decoder
  import bus_decoder_pkg::*;
#(
  parameter int                            NUM_SLAVES     = 4,
  parameter int                            ADDR_WIDTH     = 32,
  parameter int                            DATA_WIDTH     = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] BASE_ADDRS  = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] ADDR_SPANS  = {NUM_SLAVES{ADDR_WIDTH'(8)}},
  parameter bit                            ALIGNED        = 1'b1,
  parameter int                            TIMEOUT_CYCLES = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  bus_decoder_if.slave  bus
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  // Region comparators followed by a lowest-index-wins priority encoder.
  logic [NUM_SLAVES-1:0] hit;
  logic [SEL_W-1:0]      hit_idx;
  logic                  any_hit;

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_region
    region_match #(.ADDR_WIDTH(ADDR_WIDTH)) u_region_match (
      .i_base    (BASE_ADDRS[g*ADDR_WIDTH +: ADDR_WIDTH]),
      .i_span    (ADDR_SPANS[g*ADDR_WIDTH +: ADDR_WIDTH]),
      .i_address (bus.i_address),
      .o_hit     (hit[g])
    );
  end

  always_comb begin
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_idx = SEL_W'(i);
      end
    end
  end

  assign any_hit = |hit;

  state_e                 state_q, state_d;
  logic [NUM_SLAVES-1:0]  cs_q, cs_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ack_q, ack_d;
  logic                   err_q, err_d;
  err_code_e              code_q, code_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;

  // Only the latched slave's strobe and data are observed; others are ignored.
  logic                   sel_ack;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic [CNT_W-1:0]       cnt_inc;
  logic                   misaligned;

  always_comb begin
    sel_ack  = 1'b0;
    sel_data = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q == SEL_W'(i)) begin
        sel_ack  = bus.i_slave_ack[i];
        sel_data = bus.i_slave_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign cnt_inc    = cnt_q + CNT_W'(1);
  assign misaligned = ALIGNED && (bus.i_address[1:0] != 2'b00);

  always_comb begin
    state_d = state_q;
    cs_d    = cs_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    code_d  = ERR_NONE;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (bus.i_req) begin
          if (misaligned) begin
            err_d   = 1'b1;
            code_d  = ERR_ALIGN;
            state_d = RESP;
          end else if (!any_hit) begin
            err_d   = 1'b1;
            code_d  = ERR_DECODE;
            state_d = RESP;
          end else begin
            sel_d = hit_idx;
            for (int i = 0; i < NUM_SLAVES; i++) begin
              cs_d[i] = (hit_idx == SEL_W'(i));
            end
            cnt_d   = '0;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        // An ack on the limit cycle wins over the timeout.
        if (sel_ack) begin
          data_d  = sel_data;
          cs_d    = '0;
          ack_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_inc;
          if ((TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_W'(TIMEOUT_CYCLES))) begin
            cs_d    = '0;
            err_d   = 1'b1;
            code_d  = ERR_TIMEOUT;
            state_d = RESP;
          end
        end
      end
      RESP:    state_d = IDLE;  // request ignored for this one cycle
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cs_q    <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      code_q  <= code_d;
      data_q  <= data_d;
    end
  end

  assign bus.o_cs       = cs_q;
  assign bus.o_ack      = ack_q;
  assign bus.o_err      = err_q;
  assign bus.o_err_code = code_q;
  assign bus.o_data     = data_q;

endmodule

// File: tb/tb_bus_decoder.sv
// Purpose : directed bench for bus_decoder (3 regions, timeout 8) plus a top-of-space region.
// Latency : n/a.
// Backpressure: n/a.
module tb_bus_decoder;
  import bus_decoder_pkg::*;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  bus_decoder_if #(.NUM_SLAVES(3), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  bus_decoder_if #(.NUM_SLAVES(1), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_hi ();

  bus_decoder #(
    .NUM_SLAVES     (3),
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .BASE_ADDRS     ({32'h0000_1000, 32'h0000_0100, 32'h0000_0000}),
    .ADDR_SPANS     ({32'h0000_0010, 32'h0000_0100, 32'h0000_0100}),
    .ALIGNED        (1'b1),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  bus_decoder #(
    .NUM_SLAVES     (1),
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .BASE_ADDRS     (32'hFFFF_FFF0),
    .ADDR_SPANS     (32'h0000_0010),
    .ALIGNED        (1'b1),
    .TIMEOUT_CYCLES (8)
  ) dut_hi (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_hi)
  );

  // Packed status: {cs[2:0], ack, err, code[1:0]}
  logic [6:0] st;
  assign st = {bus.o_cs, bus.o_ack, bus.o_err, bus.o_err_code};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vectors++;
    if (st !== 7'b0 || bus.o_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_state got st=%b data=%h exp st=0000000 data=0", st, bus.o_data);
    end
    vectors++;
    if (bus_hi.o_cs !== 1'b0 || bus_hi.o_ack !== 1'b0 || bus_hi.o_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hi got cs=%b ack=%b err=%b exp 0", bus_hi.o_cs, bus_hi.o_ack, bus_hi.o_err);
    end
  endtask

  task automatic test_read();
    bus.i_address = 32'h104;
    bus.i_req     = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      vectors++;
      if (st !== {3'b010, 4'b0000}) begin
        miscompares++;
        $display("FAIL read_cs cycle %0d got %b exp %b", c, st, {3'b010, 4'b0000});
      end
    end
    bus.i_slave_ack = 3'b010;
    tick();
    vectors++;
    if (st !== {3'b000, 1'b1, 1'b0, 2'd0} || bus.o_data !== 32'hCAFE) begin
      miscompares++;
      $display("FAIL read_ack got st=%b data=%h exp st=0001000 data=0000cafe", st, bus.o_data);
    end
    bus.i_req       = 1'b0;
    bus.i_slave_ack = 3'b000;
    tick();
    vectors++;
    if (st !== 7'b0 || bus.o_data !== 32'hCAFE) begin
      miscompares++;
      $display("FAIL read_after got st=%b data=%h exp st=0000000 data=0000cafe", st, bus.o_data);
    end
  endtask

  task automatic test_addr_error(input logic [31:0] addr, input logic [1:0] code, input string name);
    bus.i_address = addr;
    bus.i_req     = 1'b1;
    tick();
    vectors++;
    if (st !== {3'b000, 1'b0, 1'b1, code}) begin
      miscompares++;
      $display("FAIL %s got %b exp %b", name, st, {3'b000, 1'b0, 1'b1, code});
    end
    bus.i_req = 1'b0;
    tick();
    vectors++;
    if (st !== 7'b0) begin
      miscompares++;
      $display("FAIL %s_after got %b exp 0000000", name, st);
    end
  endtask

  task automatic test_timeout();
    bus.i_address = 32'h1000;
    bus.i_req     = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      vectors++;
      if (st !== {3'b100, 4'b0000}) begin
        miscompares++;
        $display("FAIL timeout_cs cycle %0d got %b exp %b", c, st, {3'b100, 4'b0000});
      end
    end
    tick();
    vectors++;
    if (st !== {3'b000, 1'b0, 1'b1, 2'd3}) begin
      miscompares++;
      $display("FAIL timeout_err got %b exp %b", st, {3'b000, 1'b0, 1'b1, 2'd3});
    end
    bus.i_req = 1'b0;
    tick();
  endtask

  task automatic test_ack_at_limit();
    bus.i_address = 32'h100C;
    bus.i_req     = 1'b1;
    bus.i_slave_data[64 +: 32] = 32'h5A5A;
    for (int c = 1; c <= 8; c++) begin
      tick();
      vectors++;
      if (st !== {3'b100, 4'b0000}) begin
        miscompares++;
        $display("FAIL limit_cs cycle %0d got %b exp %b", c, st, {3'b100, 4'b0000});
      end
    end
    bus.i_slave_ack = 3'b100;
    tick();
    vectors++;
    if (st !== {3'b000, 1'b1, 1'b0, 2'd0} || bus.o_data !== 32'h5A5A) begin
      miscompares++;
      $display("FAIL limit_ack got st=%b data=%h exp st=0001000 data=00005a5a", st, bus.o_data);
    end
    bus.i_req       = 1'b0;
    bus.i_slave_ack = 3'b000;
    tick();
  endtask

  task automatic test_boundaries();
    // 0xFC: last word of slave 0
    bus.i_address = 32'hFC;
    bus.i_req     = 1'b1;
    tick();
    vectors++;
    if (st !== {3'b001, 4'b0000}) begin
      miscompares++;
      $display("FAIL bound_0xfc got %b exp %b", st, {3'b001, 4'b0000});
    end
    bus.i_slave_ack = 3'b001;
    tick();
    vectors++;
    if (st !== {3'b000, 1'b1, 1'b0, 2'd0} || bus.o_data !== 32'hBAD0) begin
      miscompares++;
      $display("FAIL bound_0xfc_ack got st=%b data=%h exp st=0001000 data=0000bad0", st, bus.o_data);
    end
    bus.i_req       = 1'b0;
    bus.i_slave_ack = 3'b000;
    tick();
    // 0x100: first word of slave 1
    bus.i_address = 32'h100;
    bus.i_req     = 1'b1;
    tick();
    vectors++;
    if (st !== {3'b010, 4'b0000}) begin
      miscompares++;
      $display("FAIL bound_0x100 got %b exp %b", st, {3'b010, 4'b0000});
    end
    bus.i_slave_ack = 3'b010;
    tick();
    bus.i_req       = 1'b0;
    bus.i_slave_ack = 3'b000;
    tick();
    // Region ending at 2^32
    bus_hi.i_address = 32'hFFFF_FFFC;
    bus_hi.i_req     = 1'b1;
    tick();
    vectors++;
    if (bus_hi.o_cs !== 1'b1 || bus_hi.o_err !== 1'b0) begin
      miscompares++;
      $display("FAIL top_region_cs got cs=%b err=%b exp cs=1 err=0", bus_hi.o_cs, bus_hi.o_err);
    end
    bus_hi.i_slave_ack = 1'b1;
    tick();
    vectors++;
    if (bus_hi.o_ack !== 1'b1 || bus_hi.o_data !== 32'h7777) begin
      miscompares++;
      $display("FAIL top_region_ack got ack=%b data=%h exp ack=1 data=00007777", bus_hi.o_ack, bus_hi.o_data);
    end
    bus_hi.i_req       = 1'b0;
    bus_hi.i_slave_ack = 1'b0;
    tick();
    // Just below the top region
    bus_hi.i_address = 32'hFFFF_FFEC;
    bus_hi.i_req     = 1'b1;
    tick();
    vectors++;
    if (bus_hi.o_cs !== 1'b0 || bus_hi.o_err !== 1'b1 || bus_hi.o_err_code !== ERR_DECODE) begin
      miscompares++;
      $display("FAIL top_region_below got cs=%b err=%b code=%0d exp cs=0 err=1 code=1",
               bus_hi.o_cs, bus_hi.o_err, bus_hi.o_err_code);
    end
    bus_hi.i_req = 1'b0;
    tick();
  endtask

  task automatic test_stray_ack();
    bus.i_address = 32'h104;
    bus.i_req     = 1'b1;
    tick();
    bus.i_slave_ack = 3'b001;
    bus.i_slave_data[0 +: 32] = 32'hDEAD;
    for (int c = 2; c <= 3; c++) begin
      tick();
      vectors++;
      if (st !== {3'b010, 4'b0000}) begin
        miscompares++;
        $display("FAIL stray_ignored cycle %0d got %b exp %b", c, st, {3'b010, 4'b0000});
      end
    end
    bus.i_slave_ack = 3'b010;
    bus.i_slave_data[32 +: 32] = 32'hBEEF;
    tick();
    vectors++;
    if (st !== {3'b000, 1'b1, 1'b0, 2'd0} || bus.o_data !== 32'hBEEF) begin
      miscompares++;
      $display("FAIL stray_ack got st=%b data=%h exp st=0001000 data=0000beef", st, bus.o_data);
    end
    bus.i_req       = 1'b0;
    bus.i_slave_ack = 3'b000;
    tick();
  endtask

  task automatic test_reset_mid_busy();
    bus.i_address = 32'h104;
    bus.i_req     = 1'b1;
    tick();
    vectors++;
    if (st !== {3'b010, 4'b0000}) begin
      miscompares++;
      $display("FAIL rst_busy_cs got %b exp %b", st, {3'b010, 4'b0000});
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (st !== 7'b0 || bus.o_data !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_async got st=%b data=%h exp st=0000000 data=0", st, bus.o_data);
    end
    bus.i_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    vectors++;
    if (st !== 7'b0) begin
      miscompares++;
      $display("FAIL rst_no_resume got %b exp 0000000", st);
    end
  endtask

  task automatic test_back_to_back();
    int n_acks;
    int ack_cyc [2];
    n_acks     = 0;
    ack_cyc[0] = -1;
    ack_cyc[1] = -1;
    bus.i_address = 32'h104;
    bus.i_slave_data[32 +: 32] = 32'hCAFE;
    bus.i_slave_ack = 3'b010;
    bus.i_req       = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (bus.o_ack === 1'b1) begin
        if (n_acks < 2) ack_cyc[n_acks] = c;
        n_acks++;
        if (n_acks == 2) bus.i_req = 1'b0;
      end
    end
    vectors++;
    if (n_acks != 2) begin
      miscompares++;
      $display("FAIL b2b_count got %0d acks exp 2", n_acks);
    end
    vectors++;
    if (ack_cyc[0] != 2 || ack_cyc[1] != 5) begin
      miscompares++;
      $display("FAIL b2b_cycles got %0d,%0d exp 2,5", ack_cyc[0], ack_cyc[1]);
    end
    bus.i_req       = 1'b0;
    bus.i_slave_ack = 3'b000;
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n              = 1'b0;
    bus.i_address      = '0;
    bus.i_req          = 1'b0;
    bus.i_slave_ack    = '0;
    bus.i_slave_data   = {32'hBAD2, 32'hCAFE, 32'hBAD0};
    bus_hi.i_address   = '0;
    bus_hi.i_req       = 1'b0;
    bus_hi.i_slave_ack = '0;
    bus_hi.i_slave_data = 32'h7777;
    #3;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    test_read();
    test_addr_error(32'h2000, 2'd1, "decode_miss");
    test_addr_error(32'h102,  2'd2, "misaligned");
    test_addr_error(32'h1010, 2'd1, "region2_end");
    test_timeout();
    test_ack_at_limit();
    test_boundaries();
    test_stray_ack();
    test_reset_mid_busy();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
